// File: rtl/axi_write_arbiter_if.sv
// Bundle of all client-side and master-side signals of the write arbiter.
//   master modport : the arbiter's view (drives mst_* and per-client ready/done, status)
//   slave modport  : the environment's view (clients plus downstream write core)
// Client fields are packed vectors; client i occupies slice i of each.
interface axi_write_arbiter_if #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned CLIENT_IDW  = 1,
  parameter int unsigned AXI_AWIDTH  = 32,
  parameter int unsigned AXI_DWIDTH  = 32
);
  // Client side
  logic [NUM_CLIENTS-1:0]            client_req_valid;
  logic [NUM_CLIENTS-1:0]            client_req_ready;
  logic [NUM_CLIENTS*AXI_AWIDTH-1:0] client_addr;
  logic [NUM_CLIENTS*32-1:0]         client_len;
  logic [NUM_CLIENTS*3-1:0]          client_size;
  logic [NUM_CLIENTS*2-1:0]          client_burst;
  logic [NUM_CLIENTS*AXI_DWIDTH-1:0] client_data;
  logic [NUM_CLIENTS-1:0]            client_data_valid;
  logic [NUM_CLIENTS-1:0]            client_data_ready;
  logic [NUM_CLIENTS-1:0]            client_done;
  // Downstream write core side
  logic                              mst_req_valid;
  logic                              mst_req_ready;
  logic [AXI_AWIDTH-1:0]             mst_addr;
  logic [31:0]                       mst_len;
  logic [2:0]                        mst_size;
  logic [1:0]                        mst_burst;
  logic [AXI_DWIDTH-1:0]             mst_data;
  logic                              mst_data_valid;
  logic                              mst_data_ready;
  // Status
  logic [CLIENT_IDW-1:0]             grant_id;
  logic                              busy;

  modport master (
    input  client_req_valid, client_addr, client_len, client_size, client_burst,
    input  client_data, client_data_valid, mst_req_ready, mst_data_ready,
    output client_req_ready, client_data_ready, client_done,
    output mst_req_valid, mst_addr, mst_len, mst_size, mst_burst, mst_data, mst_data_valid,
    output grant_id, busy
  );

  modport slave (
    output client_req_valid, client_addr, client_len, client_size, client_burst,
    output client_data, client_data_valid, mst_req_ready, mst_data_ready,
    input  client_req_ready, client_data_ready, client_done,
    input  mst_req_valid, mst_addr, mst_len, mst_size, mst_burst, mst_data, mst_data_valid,
    input  grant_id, busy
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter sharing one AXI write core among NUM_CLIENTS engines.
// A granted client's request is forwarded, then the data path stays locked to it
// until len+1 beats have fired, so bursts never interleave on the shared master.
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : axi_write_arbiter_if.master (client request/data channels, master
//            request/data channels, grant_id and busy status)
module axi_write_arbiter #(
  parameter int unsigned NUM_CLIENTS = 2,
  parameter int unsigned CLIENT_IDW  = 1,
  parameter int unsigned AXI_AWIDTH  = 32,
  parameter int unsigned AXI_DWIDTH  = 32
) (
  input logic                clk,
  input logic                resetn,
  axi_write_arbiter_if.master bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CLIENT_IDW-1:0] grant_q, grant_d;
  logic [CLIENT_IDW-1:0] rr_q, rr_d;
  logic [31:0]           beat_cnt_q, beat_cnt_d;
  logic [31:0]           len_q, len_d;

  logic                  any_req;
  logic [CLIENT_IDW-1:0] pick;

  logic                  sel_req_valid;
  logic                  sel_data_valid;
  logic [AXI_AWIDTH-1:0] sel_addr;
  logic [31:0]           sel_len;
  logic [2:0]            sel_size;
  logic [1:0]            sel_burst;
  logic [AXI_DWIDTH-1:0] sel_data;

  logic                  req_fire;
  logic                  beat_fire;
  logic                  last_beat;

  // First requester at or above rr_q, wrapping modulo NUM_CLIENTS.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
        if (!any_req && bus.client_req_valid[j] &&
            (j == (32'(rr_q) + i) % NUM_CLIENTS)) begin
          any_req = 1'b1;
          pick    = CLIENT_IDW'(j);
        end
      end
    end
  end

  // Fields of the granted client.
  always_comb begin
    sel_req_valid  = 1'b0;
    sel_data_valid = 1'b0;
    sel_addr       = '0;
    sel_len        = '0;
    sel_size       = '0;
    sel_burst      = '0;
    sel_data       = '0;
    for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
      if (grant_q == CLIENT_IDW'(j)) begin
        sel_req_valid  = bus.client_req_valid[j];
        sel_data_valid = bus.client_data_valid[j];
        sel_addr       = bus.client_addr[j*AXI_AWIDTH +: AXI_AWIDTH];
        sel_len        = bus.client_len[j*32 +: 32];
        sel_size       = bus.client_size[j*3 +: 3];
        sel_burst      = bus.client_burst[j*2 +: 2];
        sel_data       = bus.client_data[j*AXI_DWIDTH +: AXI_DWIDTH];
      end
    end
  end

  assign req_fire  = (state_q == StReq) && sel_req_valid && bus.mst_req_ready;
  assign beat_fire = (state_q == StData) && sel_data_valid && bus.mst_data_ready;
  assign last_beat = (beat_cnt_q == len_q);

  // Outputs are pure functions of state, so reset zeroes them without a clock edge.
  always_comb begin
    bus.mst_req_valid     = 1'b0;
    bus.mst_addr          = '0;
    bus.mst_len           = '0;
    bus.mst_size          = '0;
    bus.mst_burst         = '0;
    bus.mst_data          = '0;
    bus.mst_data_valid    = 1'b0;
    bus.client_req_ready  = '0;
    bus.client_data_ready = '0;
    bus.client_done       = '0;
    bus.busy              = (state_q != StIdle);
    bus.grant_id          = (state_q != StIdle) ? grant_q : '0;
    case (state_q)
      StReq: begin
        bus.mst_req_valid = sel_req_valid;
        bus.mst_addr      = sel_addr;
        bus.mst_len       = sel_len;
        bus.mst_size      = sel_size;
        bus.mst_burst     = sel_burst;
        for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
          if (grant_q == CLIENT_IDW'(j)) bus.client_req_ready[j] = bus.mst_req_ready;
        end
      end
      StData: begin
        bus.mst_data       = sel_data;
        bus.mst_data_valid = sel_data_valid;
        for (int unsigned j = 0; j < NUM_CLIENTS; j++) begin
          if (grant_q == CLIENT_IDW'(j)) begin
            bus.client_data_ready[j] = bus.mst_data_ready;
            bus.client_done[j]       = beat_fire && last_beat;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_d = pick;
          state_d = StReq;
        end
      end
      StReq: begin
        // A requester dropping valid here keeps its grant; no re-arbitration.
        if (req_fire) begin
          len_d      = sel_len;
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        if (beat_fire) begin
          if (last_beat) begin
            // Counter is left at the match so len=0xFFFFFFFF never wraps.
            state_d = StIdle;
            rr_d    = (grant_q == CLIENT_IDW'(NUM_CLIENTS - 1)) ? '0
                                                               : grant_q + CLIENT_IDW'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_q       <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
    end
  end

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Bench for axi_write_arbiter: a transaction-level model (grant search, remaining
// beat count) checked against every DUT output on each falling edge, plus directed
// scenarios with literal expectations.
module tb_axi_write_arbiter;
  localparam int unsigned N   = 2;
  localparam int unsigned IDW = 1;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi_write_arbiter_if #(
    .NUM_CLIENTS(N), .CLIENT_IDW(IDW), .AXI_AWIDTH(AW), .AXI_DWIDTH(DW)
  ) bus ();

  axi_write_arbiter #(
    .NUM_CLIENTS(N), .CLIENT_IDW(IDW), .AXI_AWIDTH(AW), .AXI_DWIDTH(DW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  // Per-client stimulus
  logic          c_rv    [N];
  logic [AW-1:0] c_addr  [N];
  logic [31:0]   c_len   [N];
  logic [2:0]    c_size  [N];
  logic [1:0]    c_burst [N];
  logic [DW-1:0] c_data  [N];
  logic          c_dv    [N];
  int            c_todo  [N];
  int            done_cnt[N];
  logic          m_rdy;
  logic          d_rdy;

  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      bus.client_req_valid[i]         = c_rv[i];
      bus.client_addr[i*AW +: AW]     = c_addr[i];
      bus.client_len[i*32 +: 32]      = c_len[i];
      bus.client_size[i*3 +: 3]       = c_size[i];
      bus.client_burst[i*2 +: 2]      = c_burst[i];
      bus.client_data[i*DW +: DW]     = c_data[i];
      bus.client_data_valid[i]        = c_dv[i];
    end
    bus.mst_req_ready  = m_rdy;
    bus.mst_data_ready = d_rdy;
  end

  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model state: idle / waiting for request handshake / streaming with beats left.
  bit     m_busy = 1'b0;
  bit     m_data = 1'b0;
  int     m_g = 0;
  int     m_ptr = 0;
  longint m_left = 0;

  // DUT observations for the directed checks
  int dut_grants[$];
  int fire_ids[$];
  int burst_beats = 0;
  int beats_at_done = 0;

  always @(negedge clk) begin : model_cmp
    logic [N-1:0] e_rr;
    logic [N-1:0] e_drdy;
    logic [N-1:0] e_done;
    logic         fire;
    logic         in_req;
    int           idx;
    if (!resetn) begin
      m_busy = 1'b0; m_data = 1'b0; m_g = 0; m_ptr = 0; m_left = 0;
    end
    in_req = m_busy && !m_data;
    fire   = m_data && c_dv[m_g] && d_rdy;
    e_rr   = '0;
    e_drdy = '0;
    e_done = '0;
    if (in_req && m_rdy) e_rr[m_g] = 1'b1;
    if (m_data && d_rdy) e_drdy[m_g] = 1'b1;
    if (fire && m_left == 1) e_done[m_g] = 1'b1;

    chk("busy",              64'(bus.busy),              64'(m_busy));
    chk("grant_id",          64'(bus.grant_id),          64'(m_busy ? m_g : 0));
    chk("mst_req_valid",     64'(bus.mst_req_valid),     64'(in_req && c_rv[m_g]));
    chk("mst_addr",          64'(bus.mst_addr),          64'(in_req ? c_addr[m_g] : '0));
    chk("mst_len",           64'(bus.mst_len),           64'(in_req ? c_len[m_g] : '0));
    chk("mst_size",          64'(bus.mst_size),          64'(in_req ? c_size[m_g] : '0));
    chk("mst_burst",         64'(bus.mst_burst),         64'(in_req ? c_burst[m_g] : '0));
    chk("mst_data_valid",    64'(bus.mst_data_valid),    64'(m_data && c_dv[m_g]));
    chk("mst_data",          64'(bus.mst_data),          64'(m_data ? c_data[m_g] : '0));
    chk("client_req_ready",  64'(bus.client_req_ready),  64'(e_rr));
    chk("client_data_ready", 64'(bus.client_data_ready), 64'(e_drdy));
    chk("client_done",       64'(bus.client_done),       64'(e_done));

    if (bus.mst_req_valid && bus.mst_req_ready) begin
      dut_grants.push_back(int'(bus.grant_id));
      burst_beats = 0;
    end
    if (bus.mst_data_valid && bus.mst_data_ready) begin
      fire_ids.push_back(int'(bus.grant_id));
      burst_beats++;
      if (|bus.client_done) beats_at_done = burst_beats;
    end

    if (resetn) begin
      if (!m_busy) begin
        for (int i = 0; i < int'(N); i++) begin
          idx = (m_ptr + i) % int'(N);
          if (!m_busy && c_rv[idx]) begin
            m_busy = 1'b1; m_data = 1'b0; m_g = idx;
          end
        end
      end else if (!m_data) begin
        if (c_rv[m_g] && m_rdy) begin
          m_left = longint'(c_len[m_g]) + 1;
          m_data = 1'b1;
        end
      end else if (fire) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_data = 1'b0; m_ptr = (m_g + 1) % int'(N);
        end
      end
    end
  end

  // Client behaviour: drop request once accepted and start streaming, step data
  // each accepted beat, stop streaming on done and re-request if more bursts remain.
  initial begin : responder
    logic [N-1:0] rf;
    logic [N-1:0] df;
    logic [N-1:0] dn;
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(N); i++) begin
        rf[i] = bus.client_req_valid[i] & bus.client_req_ready[i];
        df[i] = bus.client_data_valid[i] & bus.client_data_ready[i];
        dn[i] = bus.client_done[i];
      end
      @(posedge clk);
      #1;
      if (resetn) begin
        for (int i = 0; i < int'(N); i++) begin
          if (rf[i]) begin c_rv[i] = 1'b0; c_dv[i] = 1'b1; end
          if (df[i]) c_data[i] = c_data[i] + 32'h1;
          if (dn[i]) begin
            c_dv[i] = 1'b0;
            done_cnt[i]++;
            if (c_todo[i] > 0) c_todo[i]--;
            if (c_todo[i] > 0) c_rv[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int c, input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt[c] < target && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 64'(done_cnt[c] >= target), 64'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin : scenario
    int n;
    for (int i = 0; i < int'(N); i++) begin
      c_rv[i] = 1'b0; c_addr[i] = '0; c_len[i] = '0; c_dv[i] = 1'b0;
      c_todo[i] = 0; done_cnt[i] = 0;
    end
    c_data[0] = 32'hA000_0000; c_size[0] = 3'd2; c_burst[0] = 2'd1; c_addr[0] = 32'h2000;
    c_data[1] = 32'hB000_0000; c_size[1] = 3'd3; c_burst[1] = 2'd2;
    m_rdy = 1'b1;
    d_rdy = 1'b1;

    // Reset state
    tick();
    tick();
    chk("reset_busy", 64'(bus.busy), 64'(0));
    chk("reset_req_valid", 64'(bus.mst_req_valid), 64'(0));
    chk("reset_req_ready", 64'(bus.client_req_ready), 64'(0));
    resetn = 1'b1;
    tick();

    // 1: single client, len=3
    c_addr[1] = 32'h1000; c_len[1] = 32'd3; c_todo[1] = 1; c_rv[1] = 1'b1;
    tick();
    chk("t1_req_valid", 64'(bus.mst_req_valid), 64'(1));
    chk("t1_addr", 64'(bus.mst_addr), 64'h1000);
    chk("t1_len", 64'(bus.mst_len), 64'(3));
    chk("t1_grant", 64'(bus.grant_id), 64'(1));
    wait_done(1, 1, 20, "t1");
    chk("t1_beats", 64'(beats_at_done), 64'(4));
    chk("t1_busy_drop", 64'(bus.busy), 64'(0));

    // 2: contention, two bursts each, len=1
    dut_grants.delete();
    fire_ids.delete();
    c_len[0] = 32'd1; c_len[1] = 32'd1;
    c_todo[0] = 2; c_todo[1] = 2;
    c_rv[0] = 1'b1; c_rv[1] = 1'b1;
    wait_done(0, 2, 60, "t2a");
    wait_done(1, 3, 60, "t2b");
    chk("t2_ngrants", 64'(dut_grants.size()), 64'(4));
    for (int k = 0; k < 4 && k < dut_grants.size(); k++)
      chk("t2_grant_order", 64'(dut_grants[k]), 64'(k % 2));
    chk("t2_nbeats", 64'(fire_ids.size()), 64'(8));
    for (int k = 0; k < 8 && k < fire_ids.size(); k++)
      chk("t2_beat_owner", 64'(fire_ids[k]), 64'((k / 2) % 2));

    // 3: data backpressure, len=2
    c_len[0] = 32'd2; c_todo[0] = 1; c_rv[0] = 1'b1;
    n = 0;
    while (done_cnt[0] < 3 && n < 40) begin
      tick();
      d_rdy = ~d_rdy;
      n++;
    end
    chk("t3_timeout", 64'(done_cnt[0] >= 3), 64'(1));
    chk("t3_beats", 64'(beats_at_done), 64'(3));
    d_rdy = 1'b1;
    tick();

    // 4: early data held off until DATA
    m_rdy = 1'b0;
    c_len[0] = 32'd1; c_dv[0] = 1'b1; c_todo[0] = 1; c_rv[0] = 1'b1;
    tick();
    chk("t4_req_valid", 64'(bus.mst_req_valid), 64'(1));
    chk("t4_dready_req", 64'(bus.client_data_ready[0]), 64'(0));
    tick();
    chk("t4_dready_req2", 64'(bus.client_data_ready[0]), 64'(0));
    chk("t4_mst_dv_req", 64'(bus.mst_data_valid), 64'(0));
    m_rdy = 1'b1;
    tick();
    chk("t4_dready_data", 64'(bus.client_data_ready[0]), 64'(1));
    chk("t4_mst_dv_data", 64'(bus.mst_data_valid), 64'(1));
    wait_done(0, 4, 20, "t4");
    chk("t4_beats", 64'(beats_at_done), 64'(2));

    // 5: zero-length burst
    c_len[0] = 32'd0; c_todo[0] = 1; c_rv[0] = 1'b1;
    wait_done(0, 5, 20, "t5");
    chk("t5_beats", 64'(beats_at_done), 64'(1));
    chk("t5_idle", 64'(bus.busy), 64'(0));

    // 6: async reset after 2 of 5 beats, then arbitration restarts at client 0
    c_len[1] = 32'd4; c_todo[1] = 1; c_rv[1] = 1'b1;
    n = 0;
    while (!(burst_beats == 2 && bus.busy) && n < 30) begin
      tick();
      n++;
    end
    chk("t6_timeout", 64'(burst_beats == 2), 64'(1));
    resetn = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(bus.busy), 64'(0));
    chk("t6_rst_dvalid", 64'(bus.mst_data_valid), 64'(0));
    chk("t6_rst_dready", 64'(bus.client_data_ready), 64'(0));
    chk("t6_rst_grant", 64'(bus.grant_id), 64'(0));
    chk("t6_rst_data", 64'(bus.mst_data), 64'(0));
    c_dv[1] = 1'b0; c_todo[1] = 0;
    tick();
    tick();
    resetn = 1'b1;
    dut_grants.delete();
    c_len[0] = 32'd0; c_len[1] = 32'd0;
    c_todo[0] = 1; c_todo[1] = 1;
    c_rv[0] = 1'b1; c_rv[1] = 1'b1;
    wait_done(0, 6, 20, "t6a");
    wait_done(1, 4, 20, "t6b");
    chk("t6_ngrants", 64'(dut_grants.size()), 64'(2));
    if (dut_grants.size() > 0) chk("t6_first_grant", 64'(dut_grants[0]), 64'(0));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_write_arbiter.md
Name: axi_write_arbiter

Overview:
Round-robin arbiter that shares one axi_mm_write core write interface among NUM_CLIENTS accelerator engines. It grants one client's write request and forwards that request downstream. It then locks the data path to that client until all len+1 beats have transferred, and only then re-arbitrates. This guarantees that data beats from different bursts never interleave on the single write master.

Parameters:
NUM_CLIENTS, 2, number of requesting engines (>=2)
CLIENT_IDW, 1, width of grant index; must satisfy 2^CLIENT_IDW >= NUM_CLIENTS
AXI_AWIDTH, 32, address width
AXI_DWIDTH, 32, data width

Ports:
clk  input  1  clock; all logic on rising edge
resetn  input  1  asynchronous active-low reset
client_req_valid  input  NUM_CLIENTS  per-client write request valid
client_req_ready  output  NUM_CLIENTS  per-client write request accepted
client_addr  input  NUM_CLIENTS*AXI_AWIDTH  packed start addresses; client i at slice i
client_len  input  NUM_CLIENTS*32  packed beat count minus 1
client_size  input  NUM_CLIENTS*3  packed log2 bytes per beat
client_burst  input  NUM_CLIENTS*2  packed AXI burst type
client_data  input  NUM_CLIENTS*AXI_DWIDTH  packed write data
client_data_valid  input  NUM_CLIENTS  per-client data valid
client_data_ready  output  NUM_CLIENTS  per-client data ready
client_done  output  NUM_CLIENTS  one-cycle pulse when client's last beat fires
mst_req_valid  output  1  to core_write_request_valid
mst_req_ready  input  1  from core_write_request_ready
mst_addr  output  AXI_AWIDTH  to core_write_addr
mst_len  output  32  to core_write_len
mst_size  output  3  to core_write_size
mst_burst  output  2  to core_write_burst
mst_data  output  AXI_DWIDTH  to core_write_data
mst_data_valid  output  1  to core_write_data_valid
mst_data_ready  input  1  from core_write_data_ready
grant_id  output  CLIENT_IDW  currently granted client (valid when busy)
busy  output  1  high in REQ or DATA

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE, grant_id=0, rr_ptr=0, beat_cnt=0, len_reg=0. All outputs are 0 while in reset and in IDLE (all mst_* signals, client_req_ready, client_data_ready, client_done, busy). Reset mid-burst abandons the transfer; no recovery is attempted.
- FSM states are IDLE, REQ and DATA.
- IDLE:
  - If any client_req_valid bit is set, select the first set bit searching upward from rr_ptr, wrapping modulo NUM_CLIENTS.
  - Register the selection into grant_id and go to REQ.
  - Latency from client_req_valid rising to mst_req_valid is exactly 1 cycle.
- REQ:
  - mst_req_valid = client_req_valid[g].
  - mst_addr, mst_len, mst_size and mst_burst are combinationally muxed from slice g.
  - client_req_ready[g] = mst_req_ready; all other client ready bits are 0.
  - Clients must hold request fields stable while valid.
  - If client g deasserts req_valid, stay in REQ and do not re-arbitrate.
  - On mst_req_valid & mst_req_ready: len_reg <= client_len slice g, beat_cnt <= 0, go to DATA.
- DATA:
  - mst_data = client_data slice g; mst_data_valid = client_data_valid[g].
  - client_data_ready[g] = mst_data_ready; all other data ready bits are 0; all client_req_ready bits are 0.
  - On each beat fire, beat_cnt <= beat_cnt+1.
  - When a beat fires with beat_cnt==len_reg: pulse client_done[g] for that same cycle (combinational from the fire), set rr_ptr <= (g+1) mod NUM_CLIENTS, and go to IDLE.
- Counter widths:
  - beat_cnt and len_reg are 32 bits.
  - len=0xFFFFFFFF completes at beat_cnt 0xFFFFFFFF with no wrap and no increment past the match.
- Data gating:
  - In IDLE and REQ, all client_data_ready bits are 0; early client data stalls.
  - Data from non-granted clients is never forwarded.
- Re-arbitration:
  - The minimum gap between bursts is 1 IDLE cycle.
  - A requester that is granted drops to lowest priority afterwards.
- The arbiter does not split bursts or inspect len; splitting at AXI_MAX_BURST_LEN is downstream's job.

Test Plan:
1. Single client: client1 requests addr=0x1000, len=3, with mst_req_ready high -> mst_req_valid asserts 1 cycle after the request; mst_addr=0x1000, mst_len=3; exactly 4 beats are forwarded; client_done[1] pulses on the 4th beat; busy drops the next cycle.
2. Contention: both clients hold req_valid with rr_ptr=0, each len=1 -> grant order is 0,1,0,1; grant_id matches; no beat from client 1 appears during client 0's DATA.
3. Backpressure: in DATA, mst_data_ready toggles 1,0,1,0 with len=2 -> beat_cnt advances only on fire cycles; done fires on the 3rd fired beat; mst_data equals the granted client's data on every fire.
4. Early data: client0 asserts data_valid before mst_req_ready -> client_data_ready[0]=0 through IDLE/REQ; the first beat is accepted only in DATA.
5. Zero-length burst: len=0 -> one beat; done on that beat; state returns to IDLE.
6. Async reset in DATA after 2 of 5 beats -> all outputs 0 immediately (no clock edge required); after resetn rises, the next grant starts from client 0.
